// File: rtl/sr_pulse_driver.sv
// Turns two bouncy push-buttons into clean, mutually exclusive set/reset pulses for a NOR SR latch.
// Define SR_PULSE_COUNT_EN to add the 8-bit OUTpulseCnt issued-pulse counter.
module sr_pulse_driver #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 1,
    parameter int CNT_W           = 16
) (
    input  logic       INclk,
    input  logic       INreset,
    input  logic       INbtnSet,
    input  logic       INbtnReset,
    output logic       OUTset,
    output logic       OUTreset,
    output logic       OUTbusy
`ifdef SR_PULSE_COUNT_EN
    ,
    output logic [7:0] OUTpulseCnt
`endif
);

    localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, RELEASE} state_t;
    typedef enum logic {CMD_SET, CMD_RESET} cmd_t;

    // Bit 0 carries the set button, bit 1 the reset button.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic             set_q, set_d;
    logic             reset_q, reset_d;
    logic             busy_q, busy_d;

    // The counter only advances while the synchronised level disagrees, so it can never pass DEB_LAST.
    always_comb begin
        sync1_d = {INbtnReset, INbtnSet};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        rise    = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= DEB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
                rise[i]  = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it; a single cmd makes overlap impossible.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            IDLE: begin
                if (rise[1]) begin
                    state_d = PULSE;
                    cmd_d   = CMD_RESET;
                    pcnt_d  = '0;
                end else if (rise[0]) begin
                    state_d = PULSE;
                    cmd_d   = CMD_SET;
                    pcnt_d  = '0;
                end
            end
            PULSE: begin
                if (pcnt_q >= PULSE_LAST) begin
                    state_d = RELEASE;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            RELEASE: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        set_d   = (state_d == PULSE) && (cmd_d == CMD_SET);
        reset_d = (state_d == PULSE) && (cmd_d == CMD_RESET);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge INclk) begin
        if (INreset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            state_q  <= IDLE;
            cmd_q    <= CMD_SET;
            pcnt_q   <= '0;
            set_q    <= 1'b0;
            reset_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            pcnt_q   <= pcnt_d;
            set_q    <= set_d;
            reset_q  <= reset_d;
            busy_q   <= busy_d;
        end
    end

    assign OUTset   = set_q;
    assign OUTreset = reset_q;
    assign OUTbusy  = busy_q;

`ifdef SR_PULSE_COUNT_EN
    logic [7:0] pulse_cnt_q, pulse_cnt_d;

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if ((state_q == IDLE) && (state_d == PULSE)) begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge INclk) begin
        if (INreset) begin
            pulse_cnt_q <= '0;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign OUTpulseCnt = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
// The OUTpulseCnt checks are included when SR_PULSE_COUNT_EN is defined.
module tb_sr_pulse_driver;

    logic       INclk = 1'b0;
    logic       INreset;
    logic       INbtnSet;
    logic       INbtnReset;
    logic       OUTset;
    logic       OUTreset;
    logic       OUTbusy;
`ifdef SR_PULSE_COUNT_EN
    logic [7:0] OUTpulseCnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   set_pulses, reset_pulses, set_high, reset_high;
    logic prev_set, prev_reset;

    sr_pulse_driver #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (2),
        .CNT_W          (16)
    ) dut (
        .INclk      (INclk),
        .INreset    (INreset),
        .INbtnSet   (INbtnSet),
        .INbtnReset (INbtnReset),
        .OUTset     (OUTset),
        .OUTreset   (OUTreset),
        .OUTbusy    (OUTbusy)
`ifdef SR_PULSE_COUNT_EN
        ,
        .OUTpulseCnt(OUTpulseCnt)
`endif
    );

    always #5 INclk = ~INclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        set_pulses   = 0;
        reset_pulses = 0;
        set_high     = 0;
        reset_high   = 0;
        prev_set     = OUTset;
        prev_reset   = OUTreset;
    endtask

    // Drives the inputs just after an edge, then samples 1 time unit after each following edge.
    task automatic applyStimulus(input logic rst, input logic bs, input logic br, input int cycles);
        INreset    = rst;
        INbtnSet   = bs;
        INbtnReset = br;
        for (int i = 0; i < cycles; i++) begin
            @(posedge INclk);
            #1;
            checkOutput("set_reset_exclusive", {31'b0, OUTset & OUTreset}, 32'd0);
            if (OUTset && !prev_set) set_pulses++;
            if (OUTreset && !prev_reset) reset_pulses++;
            if (OUTset) set_high++;
            if (OUTreset) reset_high++;
            prev_set   = OUTset;
            prev_reset = OUTreset;
        end
    endtask

    initial begin
        prev_set   = 1'b0;
        prev_reset = 1'b0;

        // Reset held with both buttons pressed
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("reset_set", OUTset, 0);
        checkOutput("reset_reset", OUTreset, 0);
        checkOutput("reset_busy", OUTbusy, 0);
`ifdef SR_PULSE_COUNT_EN
        checkOutput("reset_cnt", OUTpulseCnt, 0);
`endif

        // Clean set press: 2 sync + 4 debounce clocks, then a 2-clock pulse
        clear_counts();
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        checkOutput("set_before_qualify", OUTset, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("set_first_cycle", OUTset, 1);
        checkOutput("busy_in_pulse", OUTbusy, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("set_second_cycle", OUTset, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("set_after_width", OUTset, 0);
        checkOutput("busy_in_release", OUTbusy, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12);
        checkOutput("clean_set_pulses", set_pulses, 1);
        checkOutput("clean_set_width", set_high, 2);
        checkOutput("clean_reset_high", reset_high, 0);
        checkOutput("busy_while_held", OUTbusy, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("busy_release_pending", OUTbusy, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 9);
        checkOutput("busy_after_release", OUTbusy, 0);

        // Bouncing reset button, then a steady hold
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2) == 0, 1);
        end
        checkOutput("bounce_no_pulse", reset_pulses, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        checkOutput("bounce_reset_pulses", reset_pulses, 1);
        checkOutput("bounce_reset_width", reset_high, 2);
        checkOutput("bounce_set_high", set_high, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("bounce_busy_idle", OUTbusy, 0);

        // Both buttons rise together: reset wins
        clear_counts();
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        checkOutput("both_reset_pulses", reset_pulses, 1);
        checkOutput("both_reset_width", reset_high, 2);
        checkOutput("both_set_high", set_high, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("both_busy_idle", OUTbusy, 0);

        // Reset pressed while set still held is ignored until both release
        clear_counts();
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("overlap_set_pulses", set_pulses, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        checkOutput("overlap_no_reset", reset_pulses, 0);
        checkOutput("overlap_busy", OUTbusy, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        checkOutput("overlap_still_no_reset", reset_pulses, 0);
        checkOutput("overlap_set_once", set_pulses, 1);
        checkOutput("overlap_busy_held", OUTbusy, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("overlap_busy_idle", OUTbusy, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        checkOutput("fresh_reset_pulse", reset_pulses, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);

        // 257 press/release cycles wrap the 8-bit counter to 1
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        clear_counts();
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 10);
            applyStimulus(1'b0, 1'b0, 1'b0, 10);
        end
        checkOutput("many_set_pulses", set_pulses, 257);
        checkOutput("many_busy_idle", OUTbusy, 0);
`ifdef SR_PULSE_COUNT_EN
        checkOutput("many_cnt_wrap", OUTpulseCnt, 1);
`endif

        // Reset mid-pulse truncates it; a held button re-qualifies afterwards
        clear_counts();
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        checkOutput("mid_set_active", OUTset, 1);
`ifdef SR_PULSE_COUNT_EN
        checkOutput("mid_cnt_before", OUTpulseCnt, 2);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("mid_set_cut", OUTset, 0);
        checkOutput("mid_reset_out", OUTreset, 0);
        checkOutput("mid_busy_cut", OUTbusy, 0);
`ifdef SR_PULSE_COUNT_EN
        checkOutput("mid_cnt_cleared", OUTpulseCnt, 0);
`endif
        clear_counts();
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        checkOutput("requal_wait", OUTset, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("requal_pulses", set_pulses, 1);
        checkOutput("requal_width", set_high, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("final_busy_idle", OUTbusy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
